// File: rtl/uart_receiver_if.sv
// uart_receiver_if -- serial line and received-byte outputs of the UART receiver.
//
// Signals:
//   rxd_orig   serial line into the receiver (asynchronous, idle high, 8N1, LSB first)
//   rx_ready   one-cycle pulse: a byte with a valid stop bit was received
//   rdata      last received byte, stable until the next good byte completes
//   ferr       one-cycle pulse: the stop bit was sampled low
//   dbg_state  current receiver FSM state, for observation only
//
// Handshake: there is no back-pressure. rx_ready is a single-cycle valid strobe
// qualifying rdata in that cycle; the consumer has no ready and must capture
// rdata on the strobe or any later cycle before the next strobe.
//
// Modports: slave = the receiver, master = whatever drives the line and
// consumes the bytes.
interface uart_receiver_if;
    logic       rxd_orig;
    logic       rx_ready;
    logic [7:0] rdata;
    logic       ferr;
    logic [2:0] dbg_state;

    modport slave (
        input  rxd_orig,
        output rx_ready,
        output rdata,
        output ferr,
        output dbg_state
    );

    modport master (
        output rxd_orig,
        input  rx_ready,
        input  rdata,
        input  ferr,
        input  dbg_state
    );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver -- 8N1 UART receiver with a two-flop input synchronizer.
//
// Ports:
//   clock   single clock, everything on its rising edge
//   reset   synchronous, active-high
//   bus     uart_receiver_if.slave: rxd_orig in; rx_ready, rdata, ferr, dbg_state out
//
// Parameter CLOCK_PER_HALF_BIT (>= 2) sets the bit period T = 2*CLOCK_PER_HALF_BIT.
// The start bit is checked mid-bit, every later bit is sampled one full T
// after the previous sample, so all samples land near bit centres.
module uart_receiver #(
    parameter int CLOCK_PER_HALF_BIT = 10
) (
    input  logic        clock,
    input  logic        reset,
    uart_receiver_if.slave bus
);
    localparam int T  = 2 * CLOCK_PER_HALF_BIT;
    localparam int CW = $clog2(T + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCK_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(T - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    rdata_q, rdata_n;
    logic          rx_ready_q, rx_ready_n;
    logic          ferr_q, ferr_n;

    logic          sync1, rxs, rxs_prev;
    logic [1:0]    fill;
    logic          seen_high;
    logic          start_edge;

    // Synchronizer. The flops reset to 1, so right after reset rxs shows a
    // fake high; "fill" marks when rxs reflects a real pin sample, and only a
    // real high arms start detection. A line held low through reset therefore
    // never looks like a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1     <= 1'b1;
            rxs       <= 1'b1;
            rxs_prev  <= 1'b1;
            fill      <= 2'b00;
            seen_high <= 1'b0;
        end else begin
            sync1    <= bus.rxd_orig;
            rxs      <= sync1;
            rxs_prev <= rxs;
            fill     <= {fill[0], 1'b1};
            if (fill[1] && rxs)
                seen_high <= 1'b1;
        end
    end

    assign start_edge = seen_high && rxs_prev && !rxs;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rdata_q    <= '0;
            rx_ready_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            rdata_q    <= rdata_n;
            rx_ready_q <= rx_ready_n;
            ferr_q     <= ferr_n;
        end
    end

    // cnt is cleared on the cycle an event is seen, so it reads k-1 on the
    // k-th cycle after it; sampling points compare against N-1.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 1'b1;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        rdata_n    = rdata_q;
        rx_ready_n = 1'b0;
        ferr_n     = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (start_edge)
                    state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    // A line back high by mid-start-bit was only a glitch.
                    state_n   = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rxs, shreg[7:1]};
                    if (bit_cnt == 3'd7)
                        state_n = STOP;
                    else
                        bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_n = '0;
                    if (rxs) begin
                        rdata_n    = shreg;
                        rx_ready_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rxs)
                    state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.rdata     = rdata_q;
    assign bus.ferr      = ferr_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver -- directed plus randomized bench for uart_receiver.
// Frames are driven on the serial pin; every rx_ready / ferr pulse is logged
// by a monitor and compared against a queue of expected events derived from
// what was sent (byte if stop bit high, framing error if stop bit low).
module tb_uart_receiver;
    localparam int H = 10;
    localparam int T = 2 * H;

    logic clock;
    logic reset;

    uart_receiver_if u_if ();

    uart_receiver #(.CLOCK_PER_HALF_BIT(H)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if.slave)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Observed events: {is_ferr, byte}; ferr events carry byte 0.
    logic [8:0] obs_q[$];
    int         obs_t[$];
    logic [8:0] exp_q[$];
    int         rd_ptr = 0;
    int         cyc = 0;
    int         overlap_viol = 0;
    logic       prev_rdy = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (u_if.rx_ready) begin
            obs_q.push_back({1'b0, u_if.rdata});
            obs_t.push_back(cyc);
        end
        if (u_if.ferr) begin
            obs_q.push_back(9'h100);
            obs_t.push_back(cyc);
        end
        if ((u_if.rx_ready && u_if.ferr) || (u_if.rx_ready && prev_rdy) || (u_if.ferr && prev_ferr))
            overlap_viol = overlap_viol + 1;
        prev_rdy  = u_if.rx_ready;
        prev_ferr = u_if.ferr;
    end

    // driver tasks
    task automatic idle(input int n);
        u_if.rxd_orig = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic hold_low(input int n);
        u_if.rxd_orig = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Drives start, 8 data bits LSB first and the stop bit; cut > 0 stops
    // driving after that many cycles, leaving the line at the current bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int cut);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10 * T; k++) begin
            if (cut > 0 && k == cut) return;
            u_if.rxd_orig = fr[k / T];
            @(negedge clock);
        end
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
        last_good = b;
    endtask

    task automatic expect_ferr();
        exp_q.push_back(9'h100);
    endtask

    // scoreboard
    task automatic check_events(input string tag);
        int n_obs;
        n_obs = obs_q.size() - rd_ptr;
        checks++;
        assert (n_obs === exp_q.size()) else begin
            errors++;
            $error("FAIL %s event_count got %0d exp %0d", tag, n_obs, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (rd_ptr + i < obs_q.size()) begin
                checks++;
                assert (obs_q[rd_ptr + i] === exp_q[i]) else begin
                    errors++;
                    $error("FAIL %s event[%0d] got %h exp %h", tag, i, obs_q[rd_ptr + i], exp_q[i]);
                end
            end
        end
        checks++;
        assert (u_if.rdata === last_good) else begin
            errors++;
            $error("FAIL %s rdata got %h exp %h", tag, u_if.rdata, last_good);
        end
        rd_ptr = obs_q.size();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        assert (u_if.rx_ready === 1'b0 && u_if.ferr === 1'b0 && u_if.rdata === 8'h00) else begin
            errors++;
            $error("FAIL %s outputs got rdy=%b ferr=%b rdata=%h exp 0/0/00", tag,
                   u_if.rx_ready, u_if.ferr, u_if.rdata);
        end
    endtask

    initial begin
        int base;
        logic [7:0] rb;
        logic       rs;

        // reset with idle line
        u_if.rxd_orig = 1'b1;
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check_reset_outputs("reset_idle");
        reset = 1'b0;
        idle(30);
        check_events("after_reset");

        // single good frame
        send_frame(8'h99, 1'b1, 0);
        expect_byte(8'h99);
        idle(2 * T);
        check_events("byte_99");

        // back-to-back frames, pulses exactly one frame apart
        base = obs_t.size();
        send_frame(8'hAA, 1'b1, 0);
        send_frame(8'h55, 1'b1, 0);
        expect_byte(8'hAA);
        expect_byte(8'h55);
        idle(2 * T);
        if (obs_t.size() >= base + 2) begin
            checks++;
            assert (obs_t[base + 1] - obs_t[base] === 10 * T) else begin
                errors++;
                $error("FAIL b2b_spacing got %0d exp %0d", obs_t[base + 1] - obs_t[base], 10 * T);
            end
        end
        check_events("b2b_aa_55");

        // short low glitch, then a real frame
        hold_low(5);
        idle(3 * T);
        check_events("glitch");
        send_frame(8'h3C, 1'b1, 0);
        expect_byte(8'h3C);
        idle(2 * T);
        check_events("after_glitch_3c");

        // framing error with extended break
        send_frame(8'h00, 1'b0, 0);
        hold_low(100);
        expect_ferr();
        idle(T);
        check_events("ferr_break");
        send_frame(8'h7E, 1'b1, 0);
        expect_byte(8'h7E);
        idle(2 * T);
        check_events("after_break_7e");

        // reset in the middle of data bit 4
        send_frame(8'hA5, 1'b1, 5 * T + H);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset_midframe");
        u_if.rxd_orig = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        last_good = 8'h00;
        idle(12 * T);
        check_events("midframe_aborted");
        send_frame(8'hF0, 1'b1, 0);
        expect_byte(8'hF0);
        idle(2 * T);
        check_events("after_reset_f0");

        // line held low through reset is not a start
        u_if.rxd_orig = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        last_good = 8'h00;
        hold_low(12 * T);
        idle(2 * T);
        check_events("low_through_reset");
        send_frame(8'hC3, 1'b1, 0);
        expect_byte(8'hC3);
        idle(2 * T);
        check_events("after_low_reset_c3");

        // randomized frames, gaps, glitches and framing errors
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                hold_low($urandom_range(1, H - 3));
                idle($urandom_range(H + 5, 2 * T));
            end
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs, 0);
            if (rs) begin
                expect_byte(rb);
                idle($urandom_range(0, 20));
            end else begin
                expect_ferr();
                hold_low($urandom_range(1, 40));
                idle($urandom_range(3, 20));
            end
        end
        idle(2 * T);
        check_events("random");

        checks++;
        assert (overlap_viol === 0) else begin
            errors++;
            $error("FAIL pulse_shape violations got %0d exp 0", overlap_viol);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
